// File: rtl/debug_dump_uart.sv
// debug_dump_uart
//   Walks the core's register file (indices 0..31) and, when asked, a window of data
//   memory. Every captured 32-bit word goes out MSB byte first inside a frame
//   {HDR_BYTE, words..., TRL_BYTE} on an 8N1 UART transmit line.
// Ports
//   clk            system clock, rising edge
//   reset          asynchronous active-low reset
//   start          1-cycle pulse, accepted only while idle
//   dump_mem_en    append the memory window after the registers
//   mem_base       first memory word address (sampled at accepted start)
//   mem_words      memory word count, saturates at 512 (sampled at accepted start)
//   swval / rdval  register-file debug read port (combinational read)
//   extmemaddress / extmemdata   data-memory debug port (synchronous read)
//   uart_tx        serial output, idles high
//   busy           high from accepted start until done
//   done           1-cycle pulse once the trailer stop bit has completed
module debug_dump_uart #(
    parameter int         CLKS_PER_BIT = 434,
    parameter logic [7:0] HDR_BYTE     = 8'hA5,
    parameter logic [7:0] TRL_BYTE     = 8'h5A
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        dump_mem_en,
    input  logic [8:0]  mem_base,
    input  logic [9:0]  mem_words,
    output logic [4:0]  swval,
    input  logic [31:0] rdval,
    output logic [8:0]  extmemaddress,
    input  logic [31:0] extmemdata,
    output logic        uart_tx,
    output logic        busy,
    output logic        done
);

    localparam int             BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_HDR    = 4'd1;
    localparam logic [3:0] S_R_ADDR = 4'd2;
    localparam logic [3:0] S_R_CAP  = 4'd3;
    localparam logic [3:0] S_R_SEND = 4'd4;
    localparam logic [3:0] S_M_ADDR = 4'd5;
    localparam logic [3:0] S_M_CAP  = 4'd6;
    localparam logic [3:0] S_M_SEND = 4'd7;
    localparam logic [3:0] S_TRL    = 4'd8;
    localparam logic [3:0] S_FIN    = 4'd9;

    // Sequencer state
    logic [3:0]  state_q, state_d;
    logic [4:0]  reg_idx_q, reg_idx_d;
    logic [8:0]  mem_addr_q, mem_addr_d;     // next memory address to visit
    logic [9:0]  mem_left_q, mem_left_d;     // memory words still to send
    logic        mem_en_q, mem_en_d;
    logic [31:0] word_q, word_d;             // captured word, shifted out MSB byte first
    logic [1:0]  byte_sel_q, byte_sel_d;
    logic [4:0]  swval_q, swval_d;
    logic [8:0]  ext_addr_q, ext_addr_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    // Byte sender state
    logic          tx_busy_q, tx_busy_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [3:0]    bit_q, bit_d;             // 0 start, 1..8 data, 9 stop
    logic [8:0]    shift_q, shift_d;         // remaining data bits with stop bit on top
    logic          tx_q, tx_d;

    logic          tx_valid;
    logic [7:0]    tx_byte;
    logic          tx_ready;

    // Ready during the last cycle of the stop bit too, so back-to-back bytes
    // leave no idle gap on the line.
    assign tx_ready = !tx_busy_q || ((bit_q == 4'd9) && (baud_q == BAUD_LAST));

    always_comb begin
        state_d    = state_q;
        reg_idx_d  = reg_idx_q;
        mem_addr_d = mem_addr_q;
        mem_left_d = mem_left_q;
        mem_en_d   = mem_en_q;
        word_d     = word_q;
        byte_sel_d = byte_sel_q;
        swval_d    = swval_q;
        ext_addr_d = ext_addr_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        tx_valid   = 1'b0;
        tx_byte    = 8'h00;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mem_addr_d = mem_base;
                    mem_left_d = (mem_words > 10'd512) ? 10'd512 : mem_words;
                    mem_en_d   = dump_mem_en;
                    busy_d     = 1'b1;
                    state_d    = S_HDR;
                end
            end
            S_HDR: begin
                tx_valid = 1'b1;
                tx_byte  = HDR_BYTE;
                if (tx_ready) begin
                    reg_idx_d = 5'd0;
                    swval_d   = 5'd0;
                    state_d   = S_R_ADDR;
                end
            end
            S_R_ADDR: state_d = S_R_CAP;
            S_R_CAP: begin
                word_d     = rdval;
                byte_sel_d = 2'd0;
                state_d    = S_R_SEND;
            end
            S_R_SEND: begin
                tx_valid = 1'b1;
                tx_byte  = word_q[31:24];
                if (tx_ready) begin
                    word_d     = {word_q[23:0], 8'h00};
                    byte_sel_d = byte_sel_q + 2'd1;
                    if (byte_sel_q == 2'd3) begin
                        if (reg_idx_q != 5'd31) begin
                            reg_idx_d = reg_idx_q + 5'd1;
                            swval_d   = reg_idx_q + 5'd1;
                            state_d   = S_R_ADDR;
                        end else if (mem_en_q && (mem_left_q != 10'd0)) begin
                            ext_addr_d = mem_addr_q;
                            mem_addr_d = mem_addr_q + 9'd1;   // natural 511 -> 0 wrap
                            state_d    = S_M_ADDR;
                        end else begin
                            state_d = S_TRL;
                        end
                    end
                end
            end
            // The address is already on the port during M_ADDR, so the
            // synchronous memory returns its word in time for M_CAP.
            S_M_ADDR: state_d = S_M_CAP;
            S_M_CAP: begin
                word_d     = extmemdata;
                byte_sel_d = 2'd0;
                state_d    = S_M_SEND;
            end
            S_M_SEND: begin
                tx_valid = 1'b1;
                tx_byte  = word_q[31:24];
                if (tx_ready) begin
                    word_d     = {word_q[23:0], 8'h00};
                    byte_sel_d = byte_sel_q + 2'd1;
                    if (byte_sel_q == 2'd3) begin
                        mem_left_d = mem_left_q - 10'd1;
                        if (mem_left_q != 10'd1) begin
                            ext_addr_d = mem_addr_q;
                            mem_addr_d = mem_addr_q + 9'd1;
                            state_d    = S_M_ADDR;
                        end else begin
                            state_d = S_TRL;
                        end
                    end
                end
            end
            S_TRL: begin
                tx_valid = 1'b1;
                tx_byte  = TRL_BYTE;
                if (tx_ready) state_d = S_FIN;
            end
            S_FIN: begin
                // Hold here until the trailer's stop bit has fully gone out.
                if (!tx_busy_q) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        tx_busy_d = tx_busy_q;
        baud_d    = baud_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        tx_d      = tx_q;

        if (tx_busy_q) begin
            if (baud_q == BAUD_LAST) begin
                baud_d = '0;
                if (bit_q == 4'd9) begin
                    tx_busy_d = 1'b0;
                end else begin
                    bit_d   = bit_q + 4'd1;
                    tx_d    = shift_q[0];
                    shift_d = {1'b1, shift_q[8:1]};
                end
            end else begin
                baud_d = baud_q + BW'(1);
            end
        end

        if (tx_valid && tx_ready) begin
            tx_busy_d = 1'b1;
            baud_d    = '0;
            bit_d     = 4'd0;
            tx_d      = 1'b0;
            shift_d   = {1'b1, tx_byte};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            reg_idx_q  <= 5'd0;
            mem_addr_q <= 9'd0;
            mem_left_q <= 10'd0;
            mem_en_q   <= 1'b0;
            word_q     <= 32'd0;
            byte_sel_q <= 2'd0;
            swval_q    <= 5'd0;
            ext_addr_q <= 9'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            tx_busy_q  <= 1'b0;
            baud_q     <= '0;
            bit_q      <= 4'd0;
            shift_q    <= 9'h1FF;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            reg_idx_q  <= reg_idx_d;
            mem_addr_q <= mem_addr_d;
            mem_left_q <= mem_left_d;
            mem_en_q   <= mem_en_d;
            word_q     <= word_d;
            byte_sel_q <= byte_sel_d;
            swval_q    <= swval_d;
            ext_addr_q <= ext_addr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            tx_busy_q  <= tx_busy_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
        end
    end

    assign swval         = swval_q;
    assign extmemaddress = ext_addr_q;
    assign uart_tx       = tx_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: tb/tb_debug_dump_uart.sv
// Bench for debug_dump_uart: a register file and a synchronous-read memory feed the
// DUT, a frame model builds the expected byte stream, and a UART receiver decodes
// uart_tx and compares each byte against the model.
module tb_debug_dump_uart;

    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        dump_mem_en = 1'b0;
    logic [8:0]  mem_base = 9'd0;
    logic [9:0]  mem_words = 10'd0;
    logic [4:0]  swval;
    logic [31:0] rdval;
    logic [8:0]  extmemaddress;
    logic [31:0] extmemdata;
    logic        uart_tx;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    debug_dump_uart #(
        .CLKS_PER_BIT (CPB),
        .HDR_BYTE     (8'hA5),
        .TRL_BYTE     (8'h5A)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .dump_mem_en   (dump_mem_en),
        .mem_base      (mem_base),
        .mem_words     (mem_words),
        .swval         (swval),
        .rdval         (rdval),
        .extmemaddress (extmemaddress),
        .extmemdata    (extmemdata),
        .uart_tx       (uart_tx),
        .busy          (busy),
        .done          (done)
    );

    // Core-side models
    logic [31:0] regs [32];
    logic [31:0] mem  [512];
    assign rdval = regs[swval];
    always @(posedge clk) extmemdata <= mem[extmemaddress];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Frame model
    logic [7:0] exp_q [$];

    task automatic build_frame(input bit en, input int base, input int words);
        int n;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        for (int r = 0; r < 32; r++)
            for (int b = 3; b >= 0; b--) exp_q.push_back(8'((regs[r] >> (8 * b)) & 32'hFF));
        n = en ? ((words > 512) ? 512 : words) : 0;
        for (int k = 0; k < n; k++) begin
            int a;
            a = (base + k) % 512;
            for (int b = 3; b >= 0; b--) exp_q.push_back(8'((mem[a] >> (8 * b)) & 32'hFF));
        end
        exp_q.push_back(8'h5A);
    endtask

    // UART receiver and per-cycle compare process
    logic       rx_active = 1'b0;
    int         rx_n = 0;
    logic [9:0] rx_bits = '0;
    logic       rx_glitch = 1'b0;
    int         rx_count = 0;
    logic [7:0] rx_log [2048];
    int         done_cnt = 0;
    logic       dump_active = 1'b0;
    logic [8:0] last_addr = 9'd0;
    int         addr_log [$];

    always @(negedge clk) begin
        if (!reset) begin
            rx_active = 1'b0;
            last_addr = extmemaddress;
        end else begin
            if (busy && extmemaddress !== last_addr) addr_log.push_back(int'(extmemaddress));
            last_addr = extmemaddress;

            if (!rx_active) begin
                if (uart_tx === 1'b0) begin
                    rx_active = 1'b1;
                    rx_n      = 0;
                    rx_bits   = '0;
                end
            end else begin
                rx_n++;
            end

            if (rx_active) begin
                if (rx_n % CPB == 0) begin
                    rx_bits[rx_n / CPB] = uart_tx;
                    rx_glitch = 1'b0;
                end else if (uart_tx !== rx_bits[rx_n / CPB]) begin
                    rx_glitch = 1'b1;
                end
                if (rx_n % CPB == CPB - 1) check("bit_hold", 32'(rx_glitch), 32'd0);
                if (rx_n == 10 * CPB - 1) begin
                    check("stop_bit", 32'(rx_bits[9]), 32'd1);
                    $display("byte %0d: %02h", rx_count, rx_bits[8:1]);
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_byte: got %02h expected none", rx_bits[8:1]);
                    end else begin
                        check("rx_byte", 32'(rx_bits[8:1]), 32'(exp_q.pop_front()));
                    end
                    if (rx_count < 2048) rx_log[rx_count] = rx_bits[8:1];
                    rx_count++;
                    rx_active = 1'b0;
                end
            end

            if (done === 1'b1) begin
                check("done_busy_low", 32'(busy), 32'd0);
                check("frame_complete", 32'(exp_q.size()), 32'd0);
                done_cnt++;
                dump_active = 1'b0;
                $display("done pulse %0d", done_cnt);
            end else if (dump_active) begin
                check("busy_held", 32'(busy), 32'd1);
            end

            if (!dump_active && !busy && !rx_active) check("idle_high", 32'(uart_tx), 32'd1);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Inputs are scrambled right after the pulse to prove they were sampled at start.
    task automatic run_start(input bit en, input int base, input int words);
        dump_mem_en = en;
        mem_base    = 9'(base);
        mem_words   = 10'(words);
        build_frame(en, base, words);
        start = 1'b1;
        @(negedge clk);
        start       = 1'b0;
        dump_active = 1'b1;
        dump_mem_en = ~en;
        mem_base    = 9'h0AA;
        mem_words   = 10'd7;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int d0;
        int k;
        d0 = done_cnt;
        k  = 0;
        while (done_cnt == d0 && k < 12000) begin
            @(negedge clk);
            k++;
        end
        check("done_seen", 32'(done_cnt - d0), 32'd1);
        tick(30);
        check("done_once", 32'(done_cnt - d0), 32'd1);
        check("busy_idle", 32'(busy), 32'd0);
    endtask

    task automatic wait_rx(input int target);
        int k;
        k = 0;
        while (rx_count < target && k < 12000) begin
            @(negedge clk);
            k++;
        end
        check("rx_reached", 32'(rx_count >= target), 32'd1);
    endtask

    int base;

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'd0;
        for (int i = 0; i < 512; i++) mem[i] = 32'd0;
        regs[1]  = 32'h0000_0005;
        regs[31] = 32'hDEAD_BEEF;
        mem[510] = 32'd1;
        mem[511] = 32'd2;
        mem[0]   = 32'd3;

        // Reset state
        tick(3);
        check("rst_swval", 32'(swval), 32'd0);
        check("rst_extaddr", 32'(extmemaddress), 32'd0);
        check("rst_uart_tx", 32'(uart_tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        reset = 1'b1;
        tick(5);

        // Registers only
        base = rx_count;
        run_start(1'b0, 0, 0);
        wait_done();
        check("s1_len", 32'(rx_count - base), 32'd130);
        check("s1_hdr", 32'(rx_log[base]), 32'hA5);
        check("s1_x1_lsb", 32'(rx_log[base + 8]), 32'h05);
        check("s1_x31_msb", 32'(rx_log[base + 125]), 32'hDE);
        check("s1_x31_lsb", 32'(rx_log[base + 128]), 32'hEF);
        check("s1_trl", 32'(rx_log[base + 129]), 32'h5A);

        // Memory window wrapping 511 -> 0
        base = rx_count;
        addr_log.delete();
        run_start(1'b1, 510, 3);
        wait_done();
        check("s2_len", 32'(rx_count - base), 32'd142);
        check("s2_m0", 32'(rx_log[base + 132]), 32'h01);
        check("s2_m1", 32'(rx_log[base + 136]), 32'h02);
        check("s2_m2", 32'(rx_log[base + 140]), 32'h03);
        check("s2_trl", 32'(rx_log[base + 141]), 32'h5A);
        check("s2_addr_cnt", 32'(addr_log.size()), 32'd3);
        if (addr_log.size() == 3) begin
            check("s2_addr0", 32'(addr_log[0]), 32'd510);
            check("s2_addr1", 32'(addr_log[1]), 32'd511);
            check("s2_addr2", 32'(addr_log[2]), 32'd0);
        end
        check("s2_addr_hold", 32'(extmemaddress), 32'd0);

        // Memory enabled with zero words
        base = rx_count;
        run_start(1'b1, 5, 0);
        wait_done();
        check("s3_len", 32'(rx_count - base), 32'd130);
        check("s3_trl", 32'(rx_log[base + 129]), 32'h5A);

        // Start re-pulsed during an active dump
        base = rx_count;
        run_start(1'b0, 0, 0);
        wait_rx(base + 5);
        dump_mem_en = 1'b1;
        mem_words   = 10'd2;
        pulse_start();
        wait_rx(base + 60);
        pulse_start();
        wait_done();
        check("s4_len", 32'(rx_count - base), 32'd130);

        // Reset in the middle of byte 40, then a fresh dump
        base = rx_count;
        run_start(1'b0, 0, 0);
        wait_rx(base + 40);
        tick(6);
        #2;
        dump_active = 1'b0;
        reset = 1'b0;
        #1;
        check("s5_tx_abort", 32'(uart_tx), 32'd1);
        check("s5_busy_abort", 32'(busy), 32'd0);
        exp_q.delete();
        tick(3);
        reset = 1'b1;
        tick(3);
        base = rx_count;
        run_start(1'b0, 0, 0);
        wait_done();
        check("s5_len", 32'(rx_count - base), 32'd130);
        check("s5_x1_lsb", 32'(rx_log[base + 8]), 32'h05);
        check("s5_trl", 32'(rx_log[base + 129]), 32'h5A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
